// File: rtl/led_pkg.sv
// Shared constants for the LED pattern sequencer: mode codes and bounce direction.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Contents:
//   MODE_ROT_L / MODE_ROT_R / MODE_BOUNCE / MODE_FILL : 2-bit run-time mode codes
//   dir_t                                             : bounce direction, DIR_L = 0, DIR_R = 1
package led_pkg;

  localparam logic [1:0] MODE_ROT_L  = 2'd0;
  localparam logic [1:0] MODE_ROT_R  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  typedef enum logic {
    DIR_L = 1'b0,
    DIR_R = 1'b1
  } dir_t;

endpackage

// File: rtl/tick_div.sv
// Prescaler: emits a tick on the last cycle of every DIV-cycle period while en is high.
// Latency: tick is combinational from the count register; first tick DIV enabled cycles after reset.
// Backpressure: en = 0 freezes the count; no tick is produced while frozen.
//
// Ports:
//   clk   in  1  clock
//   rst   in  1  synchronous active-high clear of the count (also used as a period restart)
//   en    in  1  count enable
//   tick  out 1  high when cnt == DIV-1 and en = 1
module tick_div #(
  parameter int DIV   = 5000000,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern sequencer: steps an N-bit pattern every DIV cycles (rotate L/R, bounce, fill/clear).
// Latency: pattern and step pulse update on the edge where the prescaler tick is seen.
// Backpressure: en = 0 freezes prescaler, pattern and direction; load works regardless of en.
//
// Ports:
//   clk       in  1      clock
//   rst       in  1      synchronous active-high reset
//   en        in  1      prescaler/pattern run enable
//   mode      in  2      0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 FILL (sampled at each step)
//   load      in  1      load load_val into the pattern, restart the period
//   load_val  in  WIDTH  pattern to load
//   bright    in  4      PWM brightness (only when LED_PWM_EN is defined)
//   led       out WIDTH  LED drive, 1 = lit
//   step      out 1      one-cycle pulse in the cycle after a step changed the pattern
//
// Build option: define LED_PWM_EN to add the bright port and a 4-bit PWM dimmer on led.
module led_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int DIV   = 5000000,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef LED_PWM_EN
  input  logic [3:0]       bright,
`endif
  output logic [WIDTH-1:0] led,
  output logic             step
);

  import led_pkg::*;

  localparam logic [WIDTH-1:0] PAT_RESET = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             tick;
  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] pat_nxt;
  dir_t             dir;
  dir_t             dir_nxt;

  // A load restarts the period, so it clears the prescaler exactly like reset.
  tick_div #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst | load),
    .en   (en),
    .tick (tick)
  );

  // Next pattern for a step in the current mode. Non-one-hot patterns are
  // shifted as-is; an all-zero pattern stays zero and keeps its direction.
  always_comb begin
    pat_nxt = pat;
    dir_nxt = dir;
    case (mode)
      MODE_ROT_L: pat_nxt = {pat[WIDTH-2:0], pat[WIDTH-1]};
      MODE_ROT_R: pat_nxt = {pat[0], pat[WIDTH-1:1]};
      MODE_BOUNCE: begin
        // The turn and its shift happen on the same step, so the end LED
        // is shown only once per bounce.
        if (dir == DIR_L) begin
          if (pat[WIDTH-1]) begin
            pat_nxt = pat >> 1;
            dir_nxt = DIR_R;
          end else begin
            pat_nxt = pat << 1;
          end
        end else begin
          if (pat[0]) begin
            pat_nxt = pat << 1;
            dir_nxt = DIR_L;
          end else begin
            pat_nxt = pat >> 1;
          end
        end
      end
      MODE_FILL: begin
        if (&pat) begin
          pat_nxt = '0;
        end else begin
          pat_nxt = {pat[WIDTH-2:0], 1'b1};
        end
      end
      default: pat_nxt = pat;
    endcase
  end

  // Pattern/direction state machine. Load wins over a coincident tick and
  // suppresses that step pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat  <= PAT_RESET;
      dir  <= DIR_L;
      step <= 1'b0;
    end else if (load) begin
      pat  <= load_val;
      dir  <= DIR_L;
      step <= 1'b0;
    end else if (tick) begin
      pat  <= pat_nxt;
      dir  <= dir_nxt;
      step <= 1'b1;
    end else begin
      step <= 1'b0;
    end
  end

`ifdef LED_PWM_EN
  // Free-running dimmer: a lit LED is on for 'bright' of every 16 cycles.
  logic [3:0] pwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm <= 4'd0;
    end else begin
      pwm <= pwm + 4'd1;
    end
  end

  assign led = pat & {WIDTH{pwm < bright}};
`else
  assign led = pat;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;

  localparam int W    = 4;
  localparam int DIV  = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] led;
  logic         step;
`ifdef LED_PWM_EN
  logic [3:0]   bright;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.WIDTH(W), .DIV(DIV), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
`ifdef LED_PWM_EN
    .bright   (bright),
`endif
    .led      (led),
    .step     (step)
  );

  // Reference model, kept as plain integers.
  int m_p     = 1;
  bit m_right = 0;
  int m_phase = 0;   // enabled cycles elapsed in the current period
  bit m_step  = 0;
  int m_pwm   = 0;

  function automatic void model_advance(input int md);
    case (md)
      0: m_p = ((m_p * 2) | (m_p >> (W - 1))) & MASK;
      1: m_p = (m_p / 2) | ((m_p % 2) << (W - 1));
      2: begin
        if (!m_right) begin
          if (m_p >= (1 << (W - 1))) begin m_p = m_p / 2; m_right = 1; end
          else m_p = (m_p * 2) & MASK;
        end else begin
          if (m_p % 2 == 1) begin m_p = (m_p * 2) & MASK; m_right = 0; end
          else m_p = m_p / 2;
        end
      end
      default: m_p = (m_p == MASK) ? 0 : ((m_p * 2 + 1) & MASK);
    endcase
  endfunction

  function automatic void model_clock();
    if (rst) begin
      m_p = 1; m_right = 0; m_phase = 0; m_step = 0; m_pwm = 0;
    end else begin
      m_pwm = (m_pwm + 1) % 16;
      m_step = 0;
      if (load) begin
        m_p = int'(load_val); m_right = 0; m_phase = 0;
      end else if (en) begin
        m_phase = m_phase + 1;
        if (m_phase == DIV) begin
          m_phase = 0;
          model_advance(int'(mode));
          m_step = 1;
        end
      end
    end
  endfunction

  // Brightness gate applied to an expected pattern.
  function automatic int gate(input int p);
`ifdef LED_PWM_EN
    return (m_pwm < int'(bright)) ? p : 0;
`else
    return p;
`endif
  endfunction

  task automatic chk(input string nm, input int idx, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample on the falling edge.
  task automatic cyc(input bit r, input bit e, input bit l, input bit [1:0] md, input bit [W-1:0] lv);
    rst = r; en = e; load = l; mode = md; load_val = lv;
    model_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    bit         load;
    bit [1:0]   mode;
    bit [W-1:0] lv;
    bit [W-1:0] exp_led;
    bit         exp_step;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit e, input bit l, input bit [1:0] md,
                              input bit [W-1:0] lv, input bit [W-1:0] el, input bit es);
    vec_t v;
    v.rst = r; v.en = e; v.load = l; v.mode = md; v.lv = lv; v.exp_led = el; v.exp_step = es;
    vecs.push_back(v);
  endfunction

  // One full period from a fresh period start: three quiet cycles, then the step.
  function automatic void add_period(input bit [1:0] md, input bit [W-1:0] cur, input bit [W-1:0] nxt);
    for (int k = 0; k < DIV - 1; k++) add(0, 1, 0, md, 0, cur, 0);
    add(0, 1, 0, md, 0, nxt, 1);
  endfunction

  initial begin
    bit [W-1:0] rotl [5];
    bit [W-1:0] bnc  [8];
    bit [W-1:0] fil  [7];
    int lit;

    rotl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bnc  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    fil  = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001};

    // ROT_L from reset
    add(1, 0, 0, 0, 0, 4'b0001, 0);
    for (int i = 0; i < 4; i++) add_period(0, rotl[i], rotl[i+1]);
    // BOUNCE from reset
    add(1, 0, 0, 2, 0, 4'b0001, 0);
    for (int i = 0; i < 7; i++) add_period(2, bnc[i], bnc[i+1]);
    // FILL from a loaded zero pattern
    add(0, 1, 1, 3, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 6; i++) add_period(3, fil[i], fil[i+1]);
    // Freeze with en = 0 at cnt = 2, then the step lands 2 cycles after resume
    add(1, 0, 0, 0, 0, 4'b0001, 0);
    add(0, 1, 0, 0, 0, 4'b0001, 0);
    add(0, 1, 0, 0, 0, 4'b0001, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 4'b0001, 0);
    add(0, 1, 0, 0, 0, 4'b0001, 0);
    add(0, 1, 0, 0, 0, 4'b0010, 1);
    // Load coinciding with a step: load wins, no pulse, period restarts, then ROT_R
    add(1, 0, 0, 0, 0, 4'b0001, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 4'b0001, 0);
    add(0, 1, 1, 1, 4'b1010, 4'b1010, 0);
    add_period(1, 4'b1010, 4'b0101);
    // Reset mid-period: no carry-over of the partial count
    add(1, 0, 0, 0, 0, 4'b0001, 0);
    add(0, 1, 0, 0, 0, 4'b0001, 0);
    add(0, 1, 0, 0, 0, 4'b0001, 0);
    add(1, 1, 0, 0, 0, 4'b0001, 0);
    add_period(0, 4'b0001, 4'b0010);
    // Load works while disabled; a zero pattern rotates to zero
    add(0, 0, 1, 0, 4'b0000, 4'b0000, 0);
    add_period(0, 4'b0000, 4'b0000);

`ifdef LED_PWM_EN
    bright = 4'd15;
`endif
    rst = 1; en = 0; load = 0; mode = 0; load_val = 0;
    @(negedge clk);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].mode, vecs[i].lv);
      chk("vec_led", i, int'(led), gate(int'(vecs[i].exp_led)));
      chk("vec_step", i, int'(step), int'(vecs[i].exp_step));
    end

    // Randomized run against the model
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      bit         r, e, l;
      bit [1:0]   md;
      bit [W-1:0] lv;
      r  = ($urandom_range(0, 99) == 0);
      e  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 39) == 0);
      md = 2'($urandom_range(0, 3));
      lv = W'($urandom_range(0, MASK));
`ifdef LED_PWM_EN
      bright = 4'($urandom_range(0, 15));
`endif
      cyc(r, e, l, md, lv);
      chk("rnd_led", i, int'(led), gate(m_p));
      chk("rnd_step", i, int'(step), int'(m_step));
    end

`ifdef LED_PWM_EN
    // Dimming: frozen all-on pattern, count lit cycles over two PWM periods.
    bright = 4'd4;
    cyc(0, 0, 1, 0, 4'b1111);
    lit = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("pwm_led", i, int'(led), gate(m_p));
      if (led[0]) lit++;
    end
    chk("pwm_duty4", 0, lit, 8);
    bright = 4'd0;
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (led != '0) lit++;
    end
    chk("pwm_off", 0, lit, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
